// File: rtl/uart_tx_sequencer_if.sv
// Host-side word handshake for the UART transmit sequencer.
// The host drives data/valid; the sequencer answers with ready.
interface uart_tx_sequencer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] Tx_Data;
  logic                  Tx_Valid;
  logic                  Tx_Ready;

  modport master (output Tx_Data, output Tx_Valid, input Tx_Ready);
  modport slave  (input Tx_Data, input Tx_Valid, output Tx_Ready);
endinterface

// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: takes one word per valid/ready handshake and shifts it
// out as start, LSB-first data, optional parity and stop bits on a registered line.
module uart_tx_sequencer #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                Clk,
  input  logic                Reset,
  uart_tx_sequencer_if.slave  host,
  output logic                Tx,
  output logic                Busy,
  output logic                Done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_WIDTH - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                  state_q, state_d;
  logic [BAUD_W-1:0]       baud_q, baud_d;
  logic [3:0]              bit_q, bit_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    par_q, par_d;
  logic                    tx_q, tx_d;
  logic                    ready;
  logic                    done;
  logic                    boundary;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  // tx_d always carries the value of the bit that starts on the next edge,
  // so the line itself stays a plain flop.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    tx_d     = tx_q;
    ready    = 1'b0;
    done     = 1'b0;
    boundary = (baud_q == BAUD_LAST);

    if (state_q != IDLE) begin
      baud_d = boundary ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        ready = 1'b1;
      end
      START: begin
        if (boundary) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (boundary) begin
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 4'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_d[0];
          end
        end
      end
      PARITY: begin
        if (boundary) begin
          state_d = STOP;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (boundary) begin
          if (bit_q == STOP_LAST) begin
            ready   = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Accept overrides the stop-bit exit so a waiting word starts with no idle gap.
    if (ready && host.Tx_Valid) begin
      state_d = START;
      baud_d  = '0;
      bit_d   = '0;
      shift_d = host.Tx_Data;
      par_d   = (^host.Tx_Data) ^ (PARITY_ODD != 0);
      tx_d    = 1'b0;
    end
  end

  assign host.Tx_Ready = ready;
  assign Tx            = tx_q;
  assign Busy          = (state_q != IDLE);
  assign Done          = done;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Self-checking bench: per-cycle scoreboard of expected Tx/Done/Ready plus a
// table of hand-derived frames and multi-cycle corner-case sequences.
module tb_uart_tx_sequencer;
  localparam int CPB = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] dat   = 8'h00;
  logic [2:0] vld   = 3'b000;

  always #5 clk = ~clk;

  logic tx0, tx1, tx2, busy0, busy1, busy2, done0, done1, done2;

  uart_tx_sequencer_if #(.DATA_WIDTH(8)) bus0 ();
  uart_tx_sequencer_if #(.DATA_WIDTH(8)) bus1 ();
  uart_tx_sequencer_if #(.DATA_WIDTH(8)) bus2 ();

  assign bus0.Tx_Data = dat;  assign bus0.Tx_Valid = vld[0];
  assign bus1.Tx_Data = dat;  assign bus1.Tx_Valid = vld[1];
  assign bus2.Tx_Data = dat;  assign bus2.Tx_Valid = vld[2];

  uart_tx_sequencer #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    u_dut0 (.Clk(clk), .Reset(rst_n), .host(bus0), .Tx(tx0), .Busy(busy0), .Done(done0));
  uart_tx_sequencer #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    u_dut1 (.Clk(clk), .Reset(rst_n), .host(bus1), .Tx(tx1), .Busy(busy1), .Done(done1));
  uart_tx_sequencer #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
    u_dut2 (.Clk(clk), .Reset(rst_n), .host(bus2), .Tx(tx2), .Busy(busy2), .Done(done2));

  typedef struct packed {
    logic tx;
    logic done;
    logic ready;
  } exp_t;

  // bits[i] is the i-th bit on the line (start bit first)
  typedef struct packed {
    logic [1:0]  dut;
    logic [7:0]  data;
    logic [3:0]  nbits;
    logic [10:0] bits;
  } vec_t;

  exp_t q[$];
  int   done_log[$];
  int   checks = 0, failures = 0;
  int   sel = 0, acc_cnt = 0, cyc = 0, acc_cyc = 0, since = 0, done_at = 0;
  logic mready = 1'b0;
  logic cap [0:127];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push_frame(input logic [7:0] d, input bit pen, input bit podd);
    logic seq[$];
    int   ones = 0;
    exp_t e;
    seq.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      seq.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pen) seq.push_back(podd ? ~ones[0] : ones[0]);
    seq.push_back(1'b1);
    for (int i = 0; i < seq.size(); i++) begin
      for (int c = 0; c < CPB; c++) begin
        e.tx    = seq[i];
        e.done  = (i == seq.size() - 1) && (c == CPB - 1);
        e.ready = e.done;
        q.push_back(e);
      end
    end
  endfunction

  // Scoreboard: compare the selected DUT at the falling edge, advance the model at the rising edge.
  initial begin
    logic tx_s, busy_s, done_s, rdy_s;
    exp_t e;
    forever begin
      @(negedge clk);
      case (sel)
        1:       begin tx_s = tx1; busy_s = busy1; done_s = done1; rdy_s = bus1.Tx_Ready; end
        2:       begin tx_s = tx2; busy_s = busy2; done_s = done2; rdy_s = bus2.Tx_Ready; end
        default: begin tx_s = tx0; busy_s = busy0; done_s = done0; rdy_s = bus0.Tx_Ready; end
      endcase
      if (!rst_n) begin
        mready = 1'b0;
      end else begin
        if (since < 128) cap[since] = tx_s;
        if (done_s) begin
          done_at = since;
          done_log.push_back(cyc);
        end
        if (q.size() > 0) begin
          e = q[0];
          chk("sb_tx", 32'(tx_s), 32'(e.tx));
          chk("sb_done", 32'(done_s), 32'(e.done));
          chk("sb_ready", 32'(rdy_s), 32'(e.ready));
          chk("sb_busy", 32'(busy_s), 32'd1);
          mready = e.ready;
        end else begin
          chk("idle_tx", 32'(tx_s), 32'd1);
          chk("idle_done", 32'(done_s), 32'd0);
          chk("idle_ready", 32'(rdy_s), 32'd1);
          chk("idle_busy", 32'(busy_s), 32'd0);
          mready = 1'b1;
        end
      end
      @(posedge clk);
      cyc++;
      since++;
      if (!rst_n) begin
        q.delete();
      end else begin
        if (q.size() > 0) void'(q.pop_front());
        if (vld[sel] && mready) begin
          push_frame(dat, sel != 0, sel == 2);
          acc_cnt++;
          acc_cyc = cyc;
          since   = 1;
          done_at = 0;
        end
      end
    end
  end

  task automatic wait_acc(input int c0, input int bound);
    for (int n = 0; n < bound && acc_cnt == c0; n++) @(negedge clk);
    chk("accept_seen", 32'(acc_cnt != c0), 32'd1);
  endtask

  task automatic send(input int k, input logic [7:0] d);
    int c0;
    @(negedge clk);
    sel    = k;
    dat    = d;
    vld[k] = 1'b1;
    c0     = acc_cnt;
    wait_acc(c0, 50);
    vld[k] = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 400 && q.size() != 0; n++) @(negedge clk);
    chk("frame_end_seen", 32'(q.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input int nb, input logic [10:0] bits);
    for (int i = 0; i < nb; i++)
      chk($sformatf("%s_bit%0d", tag, i), 32'(cap[i*CPB + 2]), 32'(bits[i]));
    chk($sformatf("%s_done_cycle", tag), 32'(done_at), 32'(nb * CPB));
    $display("frame %s: %0d bits, done at cycle %0d", tag, nb, done_at);
  endtask

  initial begin
    vec_t tbl [7];
    int   a1, c0;
    tbl[0] = '{dut: 2'd0, data: 8'hA5, nbits: 4'd10, bits: 11'b01101001010};
    tbl[1] = '{dut: 2'd0, data: 8'h00, nbits: 4'd10, bits: 11'b01000000000};
    tbl[2] = '{dut: 2'd0, data: 8'hFF, nbits: 4'd10, bits: 11'b01111111110};
    tbl[3] = '{dut: 2'd1, data: 8'h07, nbits: 4'd11, bits: 11'b11000001110};
    tbl[4] = '{dut: 2'd2, data: 8'h07, nbits: 4'd11, bits: 11'b10000001110};
    tbl[5] = '{dut: 2'd1, data: 8'h3C, nbits: 4'd11, bits: 11'b10001111000};
    tbl[6] = '{dut: 2'd2, data: 8'h80, nbits: 4'd11, bits: 11'b10100000000};

    // Reset held with the clock running
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx0), 32'd1);
    chk("rst_ready", 32'(bus0.Tx_Ready), 32'd1);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_tx_par_even", 32'(tx1), 32'd1);
    chk("rst_tx_par_odd", 32'(tx2), 32'd1);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      send(int'(tbl[i].dut), tbl[i].data);
      wait_idle();
      check_frame($sformatf("vec%0d_%0h", i, tbl[i].data), int'(tbl[i].nbits), tbl[i].bits);
    end

    // Back-to-back: valid held across two words
    done_log.delete();
    @(negedge clk);
    sel    = 0;
    dat    = 8'h55;
    vld[0] = 1'b1;
    wait_acc(acc_cnt, 50);
    a1  = acc_cyc;
    dat = 8'hAA;
    c0  = acc_cnt;
    wait_acc(c0, 100);
    vld[0] = 1'b0;
    chk("b2b_second_accept", 32'(acc_cyc - a1), 32'd40);
    wait_idle();
    chk("b2b_done_count", 32'(done_log.size()), 32'd2);
    if (done_log.size() >= 2) begin
      chk("b2b_done1", 32'(done_log[0] - a1 + 1), 32'd40);
      chk("b2b_done2", 32'(done_log[1] - a1 + 1), 32'd80);
    end
    $display("back-to-back 55/AA: second accept +%0d", acc_cyc - a1);

    // New valid/data while busy must not disturb the frame in flight
    send(0, 8'h12);
    repeat (10) @(negedge clk);
    dat    = 8'hFF;
    vld[0] = 1'b1;
    c0     = acc_cnt;
    repeat (8) @(negedge clk);
    vld[0] = 1'b0;
    chk("busy_valid_ignored", 32'(acc_cnt), 32'(c0));
    wait_idle();
    check_frame("busy_12", 10, 11'b01000100100);

    // Reset in the middle of data bit 3 of an all-zero frame
    send(0, 8'h00);
    for (int n = 0; n < 100 && since != 18; n++) @(negedge clk);
    chk("reached_data_bit3", 32'(since), 32'd18);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_tx", 32'(tx0), 32'd1);
    chk("midrst_ready", 32'(bus0.Tx_Ready), 32'd1);
    chk("midrst_busy", 32'(busy0), 32'd0);
    chk("midrst_done", 32'(done0), 32'd0);
    $display("reset during data bit 3: tx=%0b", tx0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    send(0, 8'h3C);
    wait_idle();
    check_frame("post_rst_3C", 10, 11'b01001111000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
